// File: rtl/aes_top.sv
// AES-128 iterative encryptor: one round per clock, round keys expanded on the fly.
// Optional build macro AES_TOP_CLEAR_ON_START_EN zeroes o_cipher when a new block is accepted.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] x2, x3, x12, x15, x240, inv;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
    always_comb begin
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_top (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [0:127] i_plain,
    input  logic [0:127] i_key,
    output logic [0:127] o_cipher,
    output logic         o_valid,
    output logic         o_busy
);
    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [0:127] state_q, key_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic [7:0]   sb [16];
    logic [7:0]   ksb [4];
    logic [0:127] shifted, mixed, next_key, round_out;
    logic [0:31]  key_temp;
    logic         last_round, accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_column(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    genvar g;
    for (g = 0; g < 16; g++) begin : g_state_sbox
        aes_sbox u_sbox (.a(state_q[8*g +: 8]), .y(sb[g]));
    end
    // Key S-boxes read the last word already rotated: bytes 13, 14, 15, 12.
    for (g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (.a(key_q[8*(12 + ((g + 1) % 4)) +: 8]), .y(ksb[g]));
    end

    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(r + 4*c) +: 8] = sb[r + 4*((c + r) % 4)];
            end
        end
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
        end
    end

    always_comb begin
        key_temp         = {ksb[0] ^ rcon_q, ksb[1], ksb[2], ksb[3]};
        next_key         = '0;
        next_key[0:31]   = key_q[0:31]   ^ key_temp;
        next_key[32:63]  = key_q[32:63]  ^ next_key[0:31];
        next_key[64:95]  = key_q[64:95]  ^ next_key[32:63];
        next_key[96:127] = key_q[96:127] ^ next_key[64:95];
        last_round       = (round_q == 4'd10);
        round_out        = (last_round ? shifted : mixed) ^ next_key;
    end

    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (i_start) begin
                    fsm_d  = S_RUN;
                    accept = 1'b1;
                end
            end
            S_RUN: begin
                if (last_round) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign o_busy = (fsm_q == S_RUN);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            key_q    <= '0;
            round_q  <= '0;
            rcon_q   <= '0;
            o_cipher <= '0;
            o_valid  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            o_valid <= 1'b0;
            if (accept) begin
                state_q <= i_plain ^ i_key;
                key_q   <= i_key;
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
`ifdef AES_TOP_CLEAR_ON_START_EN
                o_cipher <= '0;
`endif
            end else if (fsm_q == S_RUN) begin
                state_q <= round_out;
                key_q   <= next_key;
                rcon_q  <= xtime(rcon_q);
                if (last_round) begin
                    round_q  <= '0;
                    o_cipher <= round_out;
                    o_valid  <= 1'b1;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: known-answer table, randomized blocks against a byte-level
// AES model, plus hand-written sequences for ignored starts, back-to-back, reset abort and clear-on-start.

module tb_aes_top;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [0:127] plain = '0;
    logic [0:127] key = '0;
    logic [0:127] cipher;
    logic         valid;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] sbox_tab [256];

    typedef struct {
        logic [0:127] plain;
        logic [0:127] key;
        logic [0:127] cipher;
    } vec_t;

    vec_t vecs [3];

    always #5 clock = ~clock;

    aes_top dut (
        .i_clock  (clock),
        .i_reset_n(reset_n),
        .i_start  (start),
        .i_plain  (plain),
        .i_key    (key),
        .o_cipher (cipher),
        .o_valid  (valid),
        .o_busy   (busy)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Table of the S-box built by walking powers of the generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] ref_aes(input logic [0:127] pt, input logic [0:127] k);
        logic [7:0] rk [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [0:127] res;
        for (int i = 0; i < 16; i++) rk[i] = k[8*i +: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[i - 4 + j];
            if (i % 16 == 0) begin
                tmp[0] = sbox_tab[rk[i - 3]] ^ rc;
                tmp[1] = sbox_tab[rk[i - 2]];
                tmp[2] = sbox_tab[rk[i - 1]];
                tmp[3] = sbox_tab[rk[i - 4]];
                rc = mul2(rc);
            end
            for (int j = 0; j < 4; j++) rk[i + j] = rk[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r] = s[4*c + r];
                    for (int r = 0; r < 4; r++)
                        s[4*c + r] = mul2(t[r]) ^ mul2(t[(r + 1) % 4]) ^ t[(r + 1) % 4]
                                   ^ t[(r + 2) % 4] ^ t[(r + 3) % 4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*rnd + i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives a start for exactly one edge, then scrambles the data inputs.
    task automatic apply_stimulus(input logic [0:127] p, input logic [0:127] k);
        start = 1'b1;
        plain = p;
        key   = k;
        @(negedge clock);
        start = 1'b0;
        plain = {$urandom(), $urandom(), $urandom(), $urandom()};
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           valid_seen;
        int           busy_seen;
        logic [0:127] p, k, prev;

        build_sbox();
        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        reset_n = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge clock);
        check_output("reset_cipher", cipher, 128'h0);
        check_output("reset_valid", valid, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(vecs[i].plain, vecs[i].key);
            check_output("kat_busy", busy, 1'b1);
            wait_valid(lat);
            check_output("kat_latency", lat, 10);
            check_output("kat_cipher", cipher, vecs[i].cipher);
            @(negedge clock);
            check_output("kat_valid_pulse", valid, 1'b0);
            check_output("kat_busy_done", busy, 1'b0);
            check_output("kat_hold", cipher, vecs[i].cipher);
        end

        repeat (8) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 3)) @(negedge clock);
            apply_stimulus(p, k);
            wait_valid(lat);
            check_output("rand_latency", lat, 10);
            check_output("rand_cipher", cipher, ref_aes(p, k));
        end

        @(negedge clock);
        apply_stimulus(vecs[0].plain, vecs[0].key);
        repeat (3) @(negedge clock);
        start = 1'b1;
        plain = vecs[1].plain;
        key   = vecs[1].key;
        @(negedge clock);
        start = 1'b0;
        wait_valid(lat);
        check_output("ignored_start_latency", lat, 6);
        check_output("ignored_start_cipher", cipher, vecs[0].cipher);
        apply_stimulus(vecs[1].plain, vecs[1].key);
        check_output("b2b_busy", busy, 1'b1);
        wait_valid(lat);
        check_output("b2b_latency", lat, 10);
        check_output("b2b_cipher", cipher, vecs[1].cipher);

        prev = cipher;
        @(negedge clock);
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(p, k);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clock);
`ifdef AES_TOP_CLEAR_ON_START_EN
            check_output("clear_on_start", cipher, 128'h0);
`else
            check_output("hold_prior", cipher, prev);
`endif
        end
        @(negedge clock);
        check_output("second_op_valid", valid, 1'b1);
        check_output("second_op_cipher", cipher, ref_aes(p, k));

        @(negedge clock);
        apply_stimulus(vecs[2].plain, vecs[2].key);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b1;
        plain   = vecs[0].plain;
        key     = vecs[0].key;
        @(negedge clock);
        check_output("abort_cipher", cipher, 128'h0);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_valid", valid, 1'b0);
        reset_n    = 1'b1;
        start      = 1'b0;
        valid_seen = 0;
        busy_seen  = 0;
        repeat (15) begin
            @(negedge clock);
            if (valid === 1'b1) valid_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        check_output("abort_no_valid", valid_seen, 0);
        check_output("abort_no_busy", busy_seen, 0);

        apply_stimulus(vecs[1].plain, vecs[1].key);
        wait_valid(lat);
        check_output("post_reset_latency", lat, 10);
        check_output("post_reset_cipher", cipher, vecs[1].cipher);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
